// File: rtl/vga_pkg.sv
// Shared constants, arbiter state encoding and address helper for the
// superpixel memory arbiter.
//   SUPERPIX_COLS x SUPERPIX_ROWS superpixels, one DATA_W-bit entry each.
package vga_pkg;

  localparam int unsigned SUPERPIX_COLS = 20;
  localparam int unsigned SUPERPIX_ROWS = 15;
  localparam int unsigned MEM_DEPTH     = SUPERPIX_COLS * SUPERPIX_ROWS;
  localparam int unsigned ADDR_W        = 12;
  localparam int unsigned DATA_W        = 9;

  // ST_ERR is the one-cycle completion slot for an out-of-range CPU op,
  // keeping the FSM out of IDLE while the CPU sees its ack.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_ISSUE = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_CAP   = 3'd3,
    ST_WR       = 3'd4,
    ST_ERR      = 3'd5
  } arb_state_e;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned       depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the arbiter and its environment (display fetcher,
// CPU port, single-port memory).
//   slave  : arbiter view (requests and mem_rdata in, responses and memory
//            controls out)
//   master : environment view (the mirror image)
interface vga_mem_arbiter_if;
  import vga_pkg::*;

  // display fetcher
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_ovr;
  // CPU load/store
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_err;
  // memory
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output disp_valid, disp_data, disp_ovr, cpu_ack, cpu_rdata, cpu_err,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  disp_valid, disp_data, disp_ovr, cpu_ack, cpu_rdata, cpu_err,
           mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/vga_disp_pending.sv
// Holds one deferred display request raised while the arbiter is busy.
// A second request before issue overwrites the address (newest wins) and
// sets the sticky overrun flag, which only reset clears.
//   clk, reset   : clock, synchronous active-high reset
//   load_i       : capture addr_i as the pending request
//   clear_i      : pending request has been granted
//   addr_i       : display address to capture
//   pend_v_o     : a request is pending
//   pend_addr_o  : pending address
//   disp_ovr_o   : sticky overrun flag
module vga_disp_pending
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              pend_v_o,
  output logic [ADDR_W-1:0] pend_addr_o,
  output logic              disp_ovr_o
);

  logic              pend_v_q;
  logic [ADDR_W-1:0] pend_addr_q;
  logic              ovr_q;

  // Load wins over clear; the two never coincide in practice because the
  // arbiter only clears in IDLE and only loads outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      ovr_q       <= 1'b0;
    end else if (load_i) begin
      pend_v_q    <= 1'b1;
      pend_addr_q <= addr_i;
      if (pend_v_q) ovr_q <= 1'b1;
    end else if (clear_i) begin
      pend_v_q    <= 1'b0;
    end
  end

  assign pend_v_o    = pend_v_q;
  assign pend_addr_o = pend_addr_q;
  assign disp_ovr_o  = ovr_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Arbitrates the single-port superpixel memory between the display fetcher
// (absolute priority) and the CPU load/store port. One memory op in flight,
// all memory controls and responses registered.
//   clk, reset : clock, synchronous active-high reset
//   bus        : vga_mem_arbiter_if.slave (display, CPU and memory signals)
// Parameters: MEM_DEPTH (valid addresses 0..MEM_DEPTH-1), RD_LAT (memory
// read latency in cycles, >= 1).
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = vga_pkg::MEM_DEPTH,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  vga_mem_arbiter_if.slave   bus
);

  localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_disp_q;  // read in flight belongs to the display
  logic              oor_q;         // read in flight is out of range: return 0

  logic              disp_valid_q;
  logic [DATA_W-1:0] disp_data_q;
  logic              cpu_ack_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_err_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              pend_v;
  logic [ADDR_W-1:0] pend_addr;
  logic              disp_ovr;
  logic              in_idle;
  logic              pend_load;
  logic              pend_clear;
  logic              disp_sel;
  logic [ADDR_W-1:0] disp_sel_addr;
  logic [DATA_W-1:0] cap_data;

  assign in_idle       = (state_q == ST_IDLE);
  // A direct disp_req is only granted in IDLE; anywhere else it is deferred.
  assign pend_load     = bus.disp_req && !in_idle;
  assign pend_clear    = in_idle && !bus.disp_req && pend_v;
  assign disp_sel      = bus.disp_req || pend_v;
  assign disp_sel_addr = bus.disp_req ? bus.disp_addr : pend_addr;
  assign cap_data      = oor_q ? '0 : bus.mem_rdata;

  vga_disp_pending u_pending (
    .clk         (clk),
    .reset       (reset),
    .load_i      (pend_load),
    .clear_i     (pend_clear),
    .addr_i      (bus.disp_addr),
    .pend_v_o    (pend_v),
    .pend_addr_o (pend_addr),
    .disp_ovr_o  (disp_ovr)
  );

  // Arbiter FSM with registered memory controls and responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      owner_disp_q <= 1'b0;
      oor_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_err_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
    end else begin
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      mem_we_q     <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (disp_sel) begin
            // Out-of-range display reads leave mem_addr untouched and
            // walk the normal read timeline returning zero.
            owner_disp_q <= 1'b1;
            state_q      <= ST_RD_ISSUE;
            if (addr_in_range(disp_sel_addr, MEM_DEPTH)) begin
              mem_addr_q <= disp_sel_addr;
              oor_q      <= 1'b0;
            end else begin
              oor_q      <= 1'b1;
            end
          end else if (bus.cpu_req) begin
            owner_disp_q <= 1'b0;
            if (!addr_in_range(bus.cpu_addr, MEM_DEPTH)) begin
              cpu_ack_q   <= 1'b1;
              cpu_err_q   <= 1'b1;
              cpu_rdata_q <= '0;
              state_q     <= ST_ERR;
            end else if (bus.cpu_we) begin
              mem_addr_q  <= bus.cpu_addr;
              mem_wdata_q <= bus.cpu_wdata;
              mem_we_q    <= 1'b1;
              cpu_ack_q   <= 1'b1;
              cpu_err_q   <= 1'b0;
              state_q     <= ST_WR;
            end else begin
              mem_addr_q  <= bus.cpu_addr;
              oor_q       <= 1'b0;
              state_q     <= ST_RD_ISSUE;
            end
          end
        end

        ST_RD_ISSUE: begin
          if (RD_LAT == 1) begin
            state_q <= ST_RD_CAP;
          end else begin
            cnt_q   <= WAIT_INIT;
            state_q <= ST_RD_WAIT;
          end
        end

        // RD_LAT-1 extra cycles before mem_rdata is valid.
        ST_RD_WAIT: begin
          if (cnt_q == '0) state_q <= ST_RD_CAP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end

        ST_RD_CAP: begin
          if (owner_disp_q) begin
            disp_valid_q <= 1'b1;
            disp_data_q  <= cap_data;
          end else begin
            cpu_ack_q    <= 1'b1;
            cpu_rdata_q  <= cap_data;
            cpu_err_q    <= 1'b0;
          end
          state_q <= ST_IDLE;
        end

        ST_WR:   state_q <= ST_IDLE;
        ST_ERR:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.disp_valid = disp_valid_q;
  assign bus.disp_data  = disp_data_q;
  assign bus.disp_ovr   = disp_ovr;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_err    = cpu_err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: stimulus pushes expected responses
// (cycle + data) into queues, a negedge monitor pops and compares on every
// disp_valid / cpu_ack. Includes a synchronous RD_LAT=1 memory model.
module tb_vga_mem_arbiter;

  typedef struct {
    int         cyc;
    logic [8:0] data;
    logic       err;
    bit         chk_data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mem_we_cnt = 0;

  exp_t disp_exp[$];
  exp_t cpu_exp[$];

  logic [8:0] mem [0:4095];
  bit         mem_ready = 1'b0;

  vga_mem_arbiter_if bus ();

  vga_mem_arbiter #(.MEM_DEPTH(300), .RD_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8:0] pat(input int i);
    if (i == 5) return 9'h1A5;
    return 9'((i * 37 + 11) % 512);
  endfunction

  function automatic exp_t mk(input int c, input logic [8:0] d, input logic e, input bit k);
    exp_t x;
    x.cyc = c; x.data = d; x.err = e; x.chk_data = k;
    return x;
  endfunction

  // single-port memory, one cycle read latency
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      mem_ready <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_we) mem_we_cnt++;
    if (bus.disp_valid === 1'b1) begin
      if (disp_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL disp_unexpected: got disp_valid data %0h expected none (cycle %0d)",
                 bus.disp_data, cyc);
      end else begin
        e = disp_exp.pop_front();
        chk("disp_cycle", 64'(cyc), 64'(e.cyc));
        chk("disp_data", 64'(bus.disp_data), 64'(e.data));
      end
    end
    if (bus.cpu_ack === 1'b1) begin
      if (cpu_exp.size() == 0) begin
        total++; bad++;
        $display("FAIL cpu_unexpected: got cpu_ack rdata %0h expected none (cycle %0d)",
                 bus.cpu_rdata, cyc);
      end else begin
        e = cpu_exp.pop_front();
        chk("cpu_cycle", 64'(cyc), 64'(e.cyc));
        chk("cpu_err", 64'(bus.cpu_err), 64'(e.err));
        if (e.chk_data) chk("cpu_rdata", 64'(bus.cpu_rdata), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_start(input bit we, input int addr, input int wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = 12'(addr);
    bus.cpu_wdata = 9'(wdata);
  endtask

  // wait (bounded) for cpu_ack, drop the request in the ack cycle, step once more
  task automatic cpu_wait_drop();
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.cpu_ack !== 1'b1 && n < 20);
    if (bus.cpu_ack !== 1'b1) begin
      total++; bad++;
      $display("FAIL cpu_ack_timeout: got no ack expected ack within 20 cycles");
    end
    bus.cpu_req = 1'b0;
    tick();
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.disp_valid, bus.disp_data, bus.disp_ovr, bus.cpu_ack, bus.cpu_rdata,
                bus.cpu_err, bus.mem_addr, bus.mem_we, bus.mem_wdata});
  endfunction

  initial begin
    int t;
    int we0;
    reset         = 1'b1;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) tick();
    chk("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // lone display read
    t = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 12'd5;
    disp_exp.push_back(mk(t + 3, 9'h1A5, 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();
    chk("ovr_after_lone", 64'(bus.disp_ovr), 64'd0);

    // simultaneous display and CPU read: display first
    t = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 12'd7;
    cpu_start(1'b0, 8, 0);
    disp_exp.push_back(mk(t + 3, pat(7), 1'b0, 1'b1));
    cpu_exp.push_back(mk(t + 6, pat(8), 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    cpu_wait_drop();

    // CPU write at the last valid address, then read it back
    we0 = mem_we_cnt;
    t = cyc;
    cpu_start(1'b1, 299, 9'h0F0);
    cpu_exp.push_back(mk(t + 1, 9'h000, 1'b0, 1'b0));
    cpu_wait_drop();
    chk("wr299_mem_we_cycles", 64'(mem_we_cnt - we0), 64'd1);
    t = cyc;
    cpu_start(1'b0, 299, 0);
    cpu_exp.push_back(mk(t + 3, 9'h0F0, 1'b0, 1'b1));
    cpu_wait_drop();

    // out-of-range CPU read and write
    we0 = mem_we_cnt;
    t = cyc;
    cpu_start(1'b0, 300, 0);
    cpu_exp.push_back(mk(t + 1, 9'h000, 1'b1, 1'b1));
    cpu_wait_drop();
    t = cyc;
    cpu_start(1'b1, 300, 9'h1FF);
    cpu_exp.push_back(mk(t + 1, 9'h000, 1'b1, 1'b1));
    cpu_wait_drop();
    chk("oor_mem_we_cycles", 64'(mem_we_cnt - we0), 64'd0);

    // out-of-range display read returns zero on normal timing
    t = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 12'd400;
    disp_exp.push_back(mk(t + 3, 9'h000, 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();

    // two display requests during one CPU read: newest wins, overrun sticky
    t = cyc;
    cpu_start(1'b0, 10, 0);
    cpu_exp.push_back(mk(t + 3, pat(10), 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b1; bus.disp_addr = 12'd1;
    tick();
    bus.disp_addr = 12'd2;
    disp_exp.push_back(mk(t + 6, pat(2), 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    bus.cpu_req  = 1'b0;
    tick();
    chk("ovr_set", 64'(bus.disp_ovr), 64'd1);
    repeat (4) tick();
    t = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 12'd0;
    disp_exp.push_back(mk(t + 3, pat(0), 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    repeat (4) tick();
    chk("ovr_sticky", 64'(bus.disp_ovr), 64'd1);

    // reset during RD_ISSUE of a CPU read: op dropped, outputs cleared
    cpu_start(1'b0, 20, 0);
    tick();
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    tick();
    chk("reset_mid_outs", all_outs(), 64'd0);
    reset = 1'b0;
    repeat (6) tick();
    t = cyc;
    bus.disp_req = 1'b1; bus.disp_addr = 12'd7;
    disp_exp.push_back(mk(t + 3, pat(7), 1'b0, 1'b1));
    tick();
    bus.disp_req = 1'b0;
    repeat (6) tick();

    chk("disp_queue_drained", 64'(disp_exp.size()), 64'd0);
    chk("cpu_queue_drained", 64'(cpu_exp.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
